// File: rtl/fx3_bus_path_scheduler_pkg.sv
// Shared types and constants for the FX3 GPIF bus path scheduler.
package fx3_bus_path_scheduler_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StTurnaround,
      StInActive,
      StOutActive,
      StRelease
   } sched_state_e;

   localparam logic FX3_DIR_IN  = 1'b0;
   localparam logic FX3_DIR_OUT = 1'b1;

   // Width of a counter that must hold 0..max_val; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

   function automatic sched_state_e dir_active_state(input logic dir);
      return (dir == FX3_DIR_OUT) ? StOutActive : StInActive;
   endfunction

endpackage

// File: rtl/fx3_watchdog.sv
// Saturating clear/increment counter that flags the increment which reaches MAX_COUNT.
module fx3_watchdog
   import fx3_bus_path_scheduler_pkg::*;
#(
   parameter int unsigned MAX_COUNT = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam int unsigned CntW = cnt_width(MAX_COUNT);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CntW'(MAX_COUNT))) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // A zero limit disables expiry entirely.
   assign expire_o = (MAX_COUNT != 0) && inc_i && !clr_i && (cnt_q == CntW'(MAX_COUNT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fx3_bus_path_scheduler.sv
// Owns the FX3 GPIF bus: round-robin grants between the in and out path engines,
// bus-turnaround gap on direction flips, and a stall watchdog on the active path.
module fx3_bus_path_scheduler
   import fx3_bus_path_scheduler_pkg::*;
#(
   parameter int unsigned TURNAROUND_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_in_ready,
   input  logic        i_out_pending,
   input  logic        i_out_ready,
   output logic        o_in_path_enable,
   input  logic        i_in_path_finished,
   output logic        o_out_path_enable,
   input  logic        i_out_path_finished,
   input  logic        i_activity,
   output logic        o_bus_dir,
   output logic        o_idle,
   output logic        o_timeout_stb,
   output logic [15:0] o_grant_count
);

   localparam int unsigned TaW = cnt_width(TURNAROUND_CYCLES);

   sched_state_e   state_q, state_d;
   logic           dir_q, dir_d;
   logic           last_q, last_d;
   logic           stb_q, stb_d;
   logic           in_en_q, out_en_q;
   logic [TaW-1:0] ta_q, ta_d;
   logic [15:0]    grant_q, grant_d;

   logic in_req, out_req, req_dir;
   logic active, active_dir, active_fin, wd_expire;

   assign in_req  = i_in_ready;
   assign out_req = i_out_pending & i_out_ready;
   // On a tie the side not served last wins; otherwise whichever side asks.
   assign req_dir = (in_req && out_req) ? ~last_q : out_req;

   assign active     = (state_q == StInActive) || (state_q == StOutActive);
   assign active_dir = (state_q == StOutActive) ? FX3_DIR_OUT : FX3_DIR_IN;
   assign active_fin = (active_dir == FX3_DIR_OUT) ? i_out_path_finished : i_in_path_finished;

   fx3_watchdog #(
      .MAX_COUNT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (!active || i_activity),
      .inc_i    (active),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      last_d  = last_q;
      ta_d    = ta_q;
      grant_d = grant_q;
      stb_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_req || out_req) begin
               if (req_dir == dir_q) begin
                  state_d = dir_active_state(req_dir);
               end else begin
                  dir_d = req_dir;
                  if (TURNAROUND_CYCLES == 0) begin
                     state_d = dir_active_state(req_dir);
                  end else begin
                     ta_d    = TaW'(TURNAROUND_CYCLES);
                     state_d = StTurnaround;
                  end
               end
            end
         end
         StTurnaround: begin
            // The bus already points at the committed target.
            if (ta_q <= TaW'(1)) begin
               state_d = dir_active_state(dir_q);
            end else begin
               ta_d = ta_q - TaW'(1);
            end
         end
         StInActive, StOutActive: begin
            if (active_fin) begin
               state_d = StRelease;
               last_d  = active_dir;
               grant_d = grant_q + 16'd1;
            end else if (wd_expire) begin
               state_d = StRelease;
               last_d  = active_dir;
               stb_d   = 1'b1;
            end
         end
         StRelease: begin
            if (!i_in_path_finished && !i_out_path_finished) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         dir_q    <= FX3_DIR_IN;
         last_q   <= FX3_DIR_OUT;
         ta_q     <= '0;
         grant_q  <= '0;
         stb_q    <= 1'b0;
         in_en_q  <= 1'b0;
         out_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         last_q   <= last_d;
         ta_q     <= ta_d;
         grant_q  <= grant_d;
         stb_q    <= stb_d;
         in_en_q  <= (state_d == StInActive);
         out_en_q <= (state_d == StOutActive);
      end
   end

   assign o_in_path_enable  = in_en_q;
   assign o_out_path_enable = out_en_q;
   assign o_bus_dir         = dir_q;
   assign o_timeout_stb     = stb_q;
   assign o_grant_count     = grant_q;
   assign o_idle            = rst || (state_q == StIdle);

endmodule

// File: tb/tb_fx3_bus_path_scheduler.sv
// Bench: instance A (gap 4, watchdog 20) gets directed then random traffic,
// instance B (gap 0, watchdog off) gets pure random inputs; both track a grant-level model.
module tb_fx3_bus_path_scheduler;

   localparam int TA_A = 4;
   localparam int TO_A = 20;
   localparam int TA_B = 0;
   localparam int TO_B = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A signals and its engine emulation
   logic rst_a, in_ready_a, out_pend_a, out_ready_a, act_a, fin_in_a, fin_out_a;
   logic in_en_a, out_en_a, dir_a, idle_a, stb_a;
   logic [15:0] gc_a;
   logic eng_fin_in, eng_fin_out, xtra_fin_in, xtra_fin_out;
   int len_in, len_out, hold_in, hold_out, k_in, k_out, hc_in, hc_out;
   assign fin_in_a  = eng_fin_in | xtra_fin_in;
   assign fin_out_a = eng_fin_out | xtra_fin_out;

   // Instance B signals
   logic rst_b, in_ready_b, out_pend_b, out_ready_b, act_b, fin_in_b, fin_out_b;
   logic in_en_b, out_en_b, dir_b, idle_b, stb_b;
   logic [15:0] gc_b;
   bit b_go = 1'b0;

   fx3_bus_path_scheduler #(
      .TURNAROUND_CYCLES (TA_A),
      .TIMEOUT_CYCLES    (TO_A)
   ) dut_a (
      .clk                 (clk),
      .rst                 (rst_a),
      .i_in_ready          (in_ready_a),
      .i_out_pending       (out_pend_a),
      .i_out_ready         (out_ready_a),
      .o_in_path_enable    (in_en_a),
      .i_in_path_finished  (fin_in_a),
      .o_out_path_enable   (out_en_a),
      .i_out_path_finished (fin_out_a),
      .i_activity          (act_a),
      .o_bus_dir           (dir_a),
      .o_idle              (idle_a),
      .o_timeout_stb       (stb_a),
      .o_grant_count       (gc_a)
   );

   fx3_bus_path_scheduler #(
      .TURNAROUND_CYCLES (TA_B),
      .TIMEOUT_CYCLES    (TO_B)
   ) dut_b (
      .clk                 (clk),
      .rst                 (rst_b),
      .i_in_ready          (in_ready_b),
      .i_out_pending       (out_pend_b),
      .i_out_ready         (out_ready_b),
      .o_in_path_enable    (in_en_b),
      .i_in_path_finished  (fin_in_b),
      .o_out_path_enable   (out_en_b),
      .i_out_path_finished (fin_out_b),
      .i_activity          (act_b),
      .o_bus_dir           (dir_b),
      .o_idle              (idle_b),
      .o_timeout_stb       (stb_b),
      .o_grant_count       (gc_b)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Grant-level model: owner -1 none / 0 in / 1 out, gap = turnaround cycles left,
   // drain = waiting for both engines to drop finished.
   typedef struct {
      int        owner;
      int        gap;
      int        stall;
      bit        drain;
      bit        dir;
      bit        last;
      bit        stb;
      bit [15:0] cnt;
   } mdl_t;

   function automatic mdl_t mstep(input mdl_t m, input bit r, input bit inr, input bit outr,
                                  input bit fi, input bit fo, input bit act,
                                  input int ta, input int to);
      mdl_t n;
      int   tgt;
      n = m;
      if (r) begin
         n.owner = -1; n.gap = 0; n.stall = 0; n.drain = 0;
         n.dir = 0; n.last = 1; n.stb = 0; n.cnt = 0;
         return n;
      end
      n.stb = 0;
      if (m.drain) begin
         if (!fi && !fo) n.drain = 0;
      end else if (m.gap > 0) begin
         n.gap = m.gap - 1;
         if (n.gap == 0) begin
            n.owner = m.dir ? 1 : 0;
            n.stall = 0;
         end
      end else if (m.owner >= 0) begin
         if ((m.owner == 0) ? fi : fo) begin
            n.cnt = m.cnt + 16'd1;
            n.last = (m.owner == 1);
            n.owner = -1;
            n.drain = 1;
         end else if (act) begin
            n.stall = 0;
         end else begin
            n.stall = m.stall + 1;
            if (to != 0 && n.stall == to) begin
               n.stb = 1;
               n.last = (m.owner == 1);
               n.owner = -1;
               n.drain = 1;
            end
         end
      end else if (inr || outr) begin
         if (inr && outr) tgt = m.last ? 0 : 1;
         else tgt = inr ? 0 : 1;
         n.dir = (tgt == 1);
         if ((tgt == 1) == m.dir || ta == 0) begin
            n.owner = tgt;
            n.stall = 0;
         end else begin
            n.gap = ta;
         end
      end
      return n;
   endfunction

   mdl_t ma, mb;
   bit mvalid_a = 1'b0;
   bit mvalid_b = 1'b0;

   // Compare process: advance the model on each edge, check both DUTs just after it.
   always @(posedge clk) begin
      ma = mstep(ma, rst_a, in_ready_a, out_pend_a & out_ready_a, fin_in_a, fin_out_a, act_a,
                 TA_A, TO_A);
      mb = mstep(mb, rst_b, in_ready_b, out_pend_b & out_ready_b, fin_in_b, fin_out_b, act_b,
                 TA_B, TO_B);
      mvalid_a = mvalid_a | rst_a;
      mvalid_b = mvalid_b | rst_b;
      #1;
      if (mvalid_a) begin
         chk("a_in_en", in_en_a, ma.owner == 0);
         chk("a_out_en", out_en_a, ma.owner == 1);
         chk("a_dir", dir_a, ma.dir);
         chk("a_stb", stb_a, ma.stb);
         chk("a_gcount", gc_a, ma.cnt);
         chk("a_idle", idle_a, rst_a | (ma.owner < 0 && ma.gap == 0 && !ma.drain));
      end
      if (mvalid_b) begin
         chk("b_in_en", in_en_b, mb.owner == 0);
         chk("b_out_en", out_en_b, mb.owner == 1);
         chk("b_dir", dir_b, mb.dir);
         chk("b_stb", stb_b, mb.stb);
         chk("b_gcount", gc_b, mb.cnt);
         chk("b_idle", idle_b, rst_b | (mb.owner < 0 && mb.gap == 0 && !mb.drain));
      end
   end

   // Path engines for A: assert finished after len enabled cycles, hold it a while after.
   always @(negedge clk) begin
      if (in_en_a === 1'b1) begin
         k_in++;
         if (len_in > 0 && k_in >= len_in) eng_fin_in = 1'b1;
         hc_in = hold_in;
      end else begin
         k_in = 0;
         if (hc_in > 0) hc_in--;
         else eng_fin_in = 1'b0;
      end
      if (out_en_a === 1'b1) begin
         k_out++;
         if (len_out > 0 && k_out >= len_out) eng_fin_out = 1'b1;
         hc_out = hold_out;
      end else begin
         k_out = 0;
         if (hc_out > 0) hc_out--;
         else eng_fin_out = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (b_go) begin
         in_ready_b  = ($urandom_range(0, 2) == 0);
         out_pend_b  = ($urandom_range(0, 1) == 0);
         out_ready_b = ($urandom_range(0, 3) != 0);
         fin_in_b    = ($urandom_range(0, 4) == 0);
         fin_out_b   = ($urandom_range(0, 4) == 0);
         act_b       = ($urandom_range(0, 1) == 0);
         rst_b       = ($urandom_range(0, 299) == 0);
      end
   end

   task automatic wait_en(input bit side, input int limit, input string nm, output int n);
      n = 0;
      while (((side ? out_en_a : in_en_a) !== 1'b1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if ((side ? out_en_a : in_en_a) !== 1'b1) bound_fail(nm);
   endtask

   task automatic wait_low(input int limit, input string nm);
      int n = 0;
      while ((in_en_a | out_en_a) !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if ((in_en_a | out_en_a) !== 1'b0) bound_fail(nm);
   endtask

   task automatic wait_idle(input int limit, input string nm);
      int n = 0;
      while (idle_a !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (idle_a !== 1'b1) bound_fail(nm);
   endtask

   initial begin
      int n, c, gap, act_lvl;
      bit prev_dir, seen, blocked;
      logic [15:0] gc0;
      rst_a = 1; in_ready_a = 0; out_pend_a = 0; out_ready_a = 0; act_a = 0;
      xtra_fin_in = 0; xtra_fin_out = 0; eng_fin_in = 0; eng_fin_out = 0;
      len_in = 0; len_out = 0; hold_in = 0; hold_out = 0;
      k_in = 0; k_out = 0; hc_in = 0; hc_out = 0;
      rst_b = 1; in_ready_b = 0; out_pend_b = 0; out_ready_b = 0; act_b = 0;
      fin_in_b = 0; fin_out_b = 0;
      repeat (3) @(negedge clk);
      chk("rst_idle", idle_a, 1);
      chk("rst_in_en", in_en_a, 0);
      chk("rst_out_en", out_en_a, 0);
      chk("rst_dir", dir_a, 0);
      chk("rst_gcount", gc_a, 0);
      rst_a = 0;
      rst_b = 0;
      b_go  = 1;
      @(negedge clk);

      // Single inbound command, finished after 10 enabled cycles
      len_in = 10;
      in_ready_a = 1;
      wait_en(0, 20, "single_wait", n);
      in_ready_a = 0;
      chk("single_latency", n, 1);
      c = 0;
      seen = 0;
      while (in_en_a === 1'b1 && c < 40) begin
         c++;
         seen |= dir_a;
         @(negedge clk);
      end
      chk("single_en_cycles", c, 10);
      chk("single_dir_stays_in", seen, 0);
      chk("single_gcount", gc_a, 1);

      // Tie fairness: both sides requesting, 5-cycle transfers
      len_in = 5;
      len_out = 5;
      in_ready_a = 1; out_pend_a = 1; out_ready_a = 1;
      for (int g = 0; g < 4; g++) begin
         prev_dir = dir_a;
         gap = 0;
         n = 0;
         while ((in_en_a | out_en_a) !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
            if (dir_a != prev_dir && (in_en_a | out_en_a) === 1'b0) gap++;
         end
         chk("tie_side", out_en_a, (g % 2) == 0);
         chk("tie_dir", dir_a, (g % 2) == 0);
         chk("tie_gap", gap, 4);
         wait_low(30, "tie_low");
      end
      chk("tie_gcount", gc_a, 5);
      in_ready_a = 0; out_pend_a = 0; out_ready_a = 0;

      // Watchdog with opposite finished held high (must be ignored while in is active)
      wait_idle(20, "wd_idle");
      len_in = 0;
      xtra_fin_out = 1;
      in_ready_a = 1;
      wait_en(0, 20, "wd_wait", n);
      in_ready_a = 0;
      gc0 = gc_a;
      c = 0;
      while (in_en_a === 1'b1 && c < 40) begin
         c++;
         @(negedge clk);
      end
      chk("wd_en_cycles", c, 20);
      chk("wd_pulse", stb_a, 1);
      chk("wd_gcount_kept", gc_a, gc0);
      in_ready_a = 1;
      blocked = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) chk("wd_pulse_once", stb_a, 0);
         blocked |= (in_en_a | idle_a);
      end
      chk("wd_release_holds", blocked, 0);
      xtra_fin_out = 0;
      len_in = 3;
      wait_en(0, 20, "wd_regrant", n);
      in_ready_a = 0;
      chk("wd_regrant_latency", n, 2);
      wait_low(20, "wd_regrant_low");
      chk("wd_regrant_gcount", gc_a, gc0 + 16'd1);

      // Activity every 15 cycles keeps a 200-cycle transfer alive
      wait_idle(20, "act_idle");
      len_in = 0;
      in_ready_a = 1;
      wait_en(0, 20, "act_wait", n);
      in_ready_a = 0;
      gc0 = gc_a;
      seen = 0;
      blocked = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         act_a = ((i % 15) == 0);
         seen |= stb_a;
         blocked |= !in_en_a;
      end
      act_a = 0;
      chk("act_no_timeout", seen, 0);
      chk("act_en_held", blocked, 0);
      xtra_fin_in = 1;
      wait_low(10, "act_fin_low");
      xtra_fin_in = 0;
      chk("act_gcount", gc_a, gc0 + 16'd1);

      // Reset during OUT_ACTIVE
      wait_idle(20, "rst_mid_idle");
      len_out = 0;
      out_pend_a = 1; out_ready_a = 1;
      wait_en(1, 30, "rst_mid_wait", n);
      out_pend_a = 0;
      repeat (3) @(negedge clk);
      rst_a = 1;
      @(negedge clk);
      chk("rst_mid_out_en", out_en_a, 0);
      chk("rst_mid_in_en", in_en_a, 0);
      chk("rst_mid_dir", dir_a, 0);
      chk("rst_mid_idle", idle_a, 1);
      chk("rst_mid_gcount", gc_a, 0);
      rst_a = 0;
      out_ready_a = 0;

      // Random traffic on A against the model
      act_lvl = 3;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ((i % 200) == 0) act_lvl = $urandom_range(0, 5);
         in_ready_a  = ($urandom_range(0, 2) == 0);
         out_pend_a  = ($urandom_range(0, 1) == 0);
         out_ready_a = ($urandom_range(0, 3) != 0);
         act_a       = ($urandom_range(0, 9) < act_lvl);
         rst_a       = ($urandom_range(0, 399) == 0);
         if (in_en_a !== 1'b1) begin
            len_in  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 25);
            hold_in = $urandom_range(0, 2);
         end
         if (out_en_a !== 1'b1) begin
            len_out  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 25);
            hold_out = $urandom_range(0, 2);
         end
      end
      rst_a = 0;
      @(negedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
